// File: rtl/spi_xfer_sequencer_if.sv
// ---------------------------------------------------------------------------
// spi_xfer_sequencer_if
//   Command push / response pop handshake bundle for spi_xfer_sequencer.
//
//   Command channel (producer -> sequencer):
//     cmd_valid, cmd_op[1:0], cmd_wait[7:0], cmd_din_master, cmd_din_slave
//     cmd_ready (sequencer -> producer)
//   Response channel (sequencer -> consumer):
//     rsp_valid, rsp_op[1:0], rsp_dout_master, rsp_dout_slave, rsp_timeout
//     rsp_ready (consumer -> sequencer)
//
//   Modports:
//     master : the side that issues commands and consumes responses
//     slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface spi_xfer_sequencer_if #(
   parameter int unsigned SPI_TRF_BIT = 8
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_op;
   logic [7:0]             cmd_wait;
   logic [SPI_TRF_BIT-1:0] cmd_din_master;
   logic [SPI_TRF_BIT-1:0] cmd_din_slave;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [1:0]             rsp_op;
   logic [SPI_TRF_BIT-1:0] rsp_dout_master;
   logic [SPI_TRF_BIT-1:0] rsp_dout_slave;
   logic                   rsp_timeout;

   modport master (
      output cmd_valid, cmd_op, cmd_wait, cmd_din_master, cmd_din_slave,
      input  cmd_ready,
      input  rsp_valid, rsp_op, rsp_dout_master, rsp_dout_slave, rsp_timeout,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_wait, cmd_din_master, cmd_din_slave,
      output cmd_ready,
      output rsp_valid, rsp_op, rsp_dout_master, rsp_dout_slave, rsp_timeout,
      input  rsp_ready
   );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// spi_xfer_sequencer
//   Queues SPI transfer commands in a small FIFO and issues them one at a
//   time to spi_top, waits for completion (or a timeout) and returns a
//   response per command, strictly in order.
//
//   Ports:
//     clk, rst       : clock, asynchronous active-high reset
//     bus (slave)    : command push / response pop handshakes
//     req            : one-cycle transfer request to spi_top (00 = none)
//     wait_duration  : wait value for the current transfer
//     din_master     : master transmit word for the current transfer
//     din_slave      : slave transmit word for the current transfer
//     dout_master    : master receive word from spi_top
//     dout_slave     : slave receive word from spi_top
//     done_tx        : spi_top transmit-complete pulse
//     done_rx        : spi_top receive-complete pulse
//     busy           : high whenever a command is being processed
// ---------------------------------------------------------------------------
module spi_xfer_sequencer #(
   parameter int unsigned SPI_TRF_BIT    = 8,
   parameter int unsigned CMD_DEPTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_xfer_sequencer_if.slave    bus,
   output logic [1:0]             req,
   output logic [7:0]             wait_duration,
   output logic [SPI_TRF_BIT-1:0] din_master,
   output logic [SPI_TRF_BIT-1:0] din_slave,
   input  logic [SPI_TRF_BIT-1:0] dout_master,
   input  logic [SPI_TRF_BIT-1:0] dout_slave,
   input  logic                   done_tx,
   input  logic                   done_rx,
   output logic                   busy
);

   localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_DEPTH);

   typedef struct packed {
      logic [1:0]             op;
      logic [7:0]             wt;
      logic [SPI_TRF_BIT-1:0] dm;
      logic [SPI_TRF_BIT-1:0] ds;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESP
   } state_t;

   cmd_t                   fifo_mem [CMD_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   cmd_t                   cmd_in;
   cmd_t                   hold;

   state_t                 state_q;
   state_t                 state_d;
   logic [TMO_W-1:0]       tmo_cnt;
   logic                   tmo_hit;
   logic                   tx_seen;
   logic                   rx_seen;
   logic                   xfer_done;
   logic [1:0]             req_d;
   logic                   rsp_load;
   logic                   rsp_take_data;
   logic                   rsp_tmo_d;

   logic [1:0]             rsp_op_q;
   logic [SPI_TRF_BIT-1:0] rsp_dm_q;
   logic [SPI_TRF_BIT-1:0] rsp_ds_q;
   logic                   rsp_tmo_q;

   // ---------------- command FIFO ----------------
   assign full          = (count == CNT_FULL);
   assign empty         = (count == '0);
   assign bus.cmd_ready = !full;
   assign push          = bus.cmd_valid && !full;
   assign cmd_in        = '{op: bus.cmd_op, wt: bus.cmd_wait,
                            dm: bus.cmd_din_master, ds: bus.cmd_din_slave};

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= cmd_in;
      end
   end

   // Depth is a power of two, so plain pointer increments wrap correctly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------- completion detection ----------------
   // For op 11 each done line is remembered independently, so the two
   // pulses may arrive in either order or together.
   always_comb begin
      unique case (hold.op)
         2'b01:   xfer_done = done_tx;
         2'b10:   xfer_done = done_rx;
         2'b11:   xfer_done = (tx_seen | done_tx) & (rx_seen | done_rx);
         default: xfer_done = 1'b0;
      endcase
   end

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      req_d         = 2'b00;
      rsp_load      = 1'b0;
      rsp_take_data = 1'b0;
      rsp_tmo_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (hold.op == 2'b00) begin
               rsp_load = 1'b1;
               state_d  = RESP;
            end else begin
               req_d   = hold.op;
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (xfer_done) begin
               rsp_load      = 1'b1;
               rsp_take_data = 1'b1;
               state_d       = RESP;
            end else if (tmo_hit) begin
               rsp_load  = 1'b1;
               rsp_tmo_d = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   // req is registered: the pulse is raised on the ISSUE->WAIT_DONE edge and
   // therefore appears during the first WAIT_DONE cycle, lasting one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= '0;
         req       <= '0;
         tmo_cnt   <= '0;
         tx_seen   <= 1'b0;
         rx_seen   <= 1'b0;
         rsp_op_q  <= '0;
         rsp_dm_q  <= '0;
         rsp_ds_q  <= '0;
         rsp_tmo_q <= 1'b0;
      end else begin
         req <= req_d;
         if (pop) begin
            hold <= fifo_mem[rd_ptr];
         end
         if (state_q == ISSUE) begin
            tmo_cnt <= '0;
            tx_seen <= 1'b0;
            rx_seen <= 1'b0;
         end else if (state_q == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            tx_seen <= tx_seen | done_tx;
            rx_seen <= rx_seen | done_rx;
         end
         if (rsp_load) begin
            rsp_op_q  <= hold.op;
            rsp_dm_q  <= rsp_take_data ? dout_master : '0;
            rsp_ds_q  <= rsp_take_data ? dout_slave  : '0;
            rsp_tmo_q <= rsp_tmo_d;
         end
      end
   end

   // ---------------- outputs ----------------
   assign wait_duration       = hold.wt;
   assign din_master          = hold.dm;
   assign din_slave           = hold.ds;
   assign busy                = (state_q != IDLE);
   assign bus.rsp_valid       = (state_q == RESP);
   assign bus.rsp_op          = rsp_op_q;
   assign bus.rsp_dout_master = rsp_dm_q;
   assign bus.rsp_dout_slave  = rsp_ds_q;
   assign bus.rsp_timeout     = rsp_tmo_q;

endmodule
